// File: rtl/char_pkg.sv
// rtl/char_pkg.sv - shared code map, font geometry and character code type
package char_pkg;

  localparam int CODE_W = 6;

  localparam logic [CODE_W-1:0] CODE_BLANK  = 6'd0;
  localparam logic [CODE_W-1:0] CODE_DIGIT0 = 6'd1;
  localparam logic [CODE_W-1:0] CODE_A      = 6'd11;
  localparam logic [CODE_W-1:0] CODE_MAX    = 6'd36;

  localparam int FONT_W = 5;
  localparam int FONT_H = 8;

  typedef logic [CODE_W-1:0] char_code_t;

endpackage

// File: rtl/glyph_rom.sv
// rtl/glyph_rom.sv - combinational 5x8 font; row 0 is the top row, bit 4 the leftmost column
module glyph_rom
  import char_pkg::*;
(
  input  char_code_t        i_code,
  input  logic [2:0]        i_row,
  output logic [FONT_W-1:0] o_bits
);

  logic [FONT_W*FONT_H-1:0] w_glyph;

  // Each glyph is eight 5-bit rows packed top row first.
  always_comb begin
    w_glyph = '0;
    case (i_code)
      6'd1:  w_glyph = 40'b01110_10001_10011_10101_11001_10001_10001_01110;
      6'd2:  w_glyph = 40'b00100_01100_00100_00100_00100_00100_00100_01110;
      6'd3:  w_glyph = 40'b01110_10001_00001_00010_00100_01000_10000_11111;
      6'd4:  w_glyph = 40'b11111_00010_00100_00010_00001_00001_10001_01110;
      6'd5:  w_glyph = 40'b00010_00110_01010_10010_11111_00010_00010_00010;
      6'd6:  w_glyph = 40'b11111_10000_11110_00001_00001_00001_10001_01110;
      6'd7:  w_glyph = 40'b00110_01000_10000_11110_10001_10001_10001_01110;
      6'd8:  w_glyph = 40'b11111_00001_00010_00100_01000_01000_01000_01000;
      6'd9:  w_glyph = 40'b01110_10001_10001_01110_10001_10001_10001_01110;
      6'd10: w_glyph = 40'b01110_10001_10001_01111_00001_00001_00010_01100;
      6'd11: w_glyph = 40'b01110_10001_10001_10001_11111_10001_10001_10001;
      6'd12: w_glyph = 40'b11110_10001_10001_11110_10001_10001_10001_11110;
      6'd13: w_glyph = 40'b01110_10001_10000_10000_10000_10000_10001_01110;
      6'd14: w_glyph = 40'b11110_10001_10001_10001_10001_10001_10001_11110;
      6'd15: w_glyph = 40'b11111_10000_10000_11110_10000_10000_10000_11111;
      6'd16: w_glyph = 40'b11111_10000_10000_11110_10000_10000_10000_10000;
      6'd17: w_glyph = 40'b01110_10001_10000_10111_10001_10001_10001_01111;
      6'd18: w_glyph = 40'b10001_10001_10001_11111_10001_10001_10001_10001;
      6'd19: w_glyph = 40'b01110_00100_00100_00100_00100_00100_00100_01110;
      6'd20: w_glyph = 40'b00111_00010_00010_00010_00010_00010_10010_01100;
      6'd21: w_glyph = 40'b10001_10010_10100_11000_10100_10010_10001_10001;
      6'd22: w_glyph = 40'b10000_10000_10000_10000_10000_10000_10000_11111;
      6'd23: w_glyph = 40'b10001_11011_10101_10101_10001_10001_10001_10001;
      6'd24: w_glyph = 40'b10001_10001_11001_10101_10011_10001_10001_10001;
      6'd25: w_glyph = 40'b01110_10001_10001_10001_10001_10001_10001_01110;
      6'd26: w_glyph = 40'b11110_10001_10001_11110_10000_10000_10000_10000;
      6'd27: w_glyph = 40'b01110_10001_10001_10001_10001_10101_10010_01101;
      6'd28: w_glyph = 40'b11110_10001_10001_11110_10100_10010_10001_10001;
      6'd29: w_glyph = 40'b01111_10000_10000_01110_00001_00001_00001_11110;
      6'd30: w_glyph = 40'b11111_00100_00100_00100_00100_00100_00100_00100;
      6'd31: w_glyph = 40'b10001_10001_10001_10001_10001_10001_10001_01110;
      6'd32: w_glyph = 40'b10001_10001_10001_10001_10001_10001_01010_00100;
      6'd33: w_glyph = 40'b10001_10001_10001_10101_10101_10101_10101_01010;
      6'd34: w_glyph = 40'b10001_10001_01010_00100_01010_10001_10001_10001;
      6'd35: w_glyph = 40'b10001_10001_01010_00100_00100_00100_00100_00100;
      6'd36: w_glyph = 40'b11111_00001_00010_00100_01000_10000_10000_11111;
      default: w_glyph = '0;
    endcase
    o_bits = w_glyph[(FONT_W*FONT_H-1) - FONT_W*int'(i_row) -: FONT_W];
  end

endmodule

// File: rtl/char_string_renderer.sv
// rtl/char_string_renderer.sv - 2-cycle pipelined string renderer with frame-synchronous commit
// Optional blink of masked cells is built when CHAR_BLINK_EN is defined.
module char_string_renderer
  import char_pkg::*;
#(
  parameter int N_CHARS      = 4,
  parameter int CODE_W       = char_pkg::CODE_W,
  parameter int SCALE        = 5,
  parameter int GAP          = 5,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [9:0]                x,
  input  logic [9:0]                y,
  input  logic [9:0]                start_x,
  input  logic [9:0]                start_y,
  input  logic                      frame_start,
  input  logic                      load,
  input  logic [N_CHARS*CODE_W-1:0] codes,
  input  logic [N_CHARS-1:0]        blink_mask,
  output logic                      pending,
  output logic                      display
);

  localparam int PITCH  = FONT_W*SCALE + GAP;
  localparam int BOX_W  = N_CHARS*PITCH - GAP;
  localparam int BOX_H  = FONT_H*SCALE;
  localparam int CELL_W = (N_CHARS > 1) ? $clog2(N_CHARS) : 1;

  logic [N_CHARS*CODE_W-1:0] r_active;
  logic [N_CHARS*CODE_W-1:0] r_shadow;
  logic                      r_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (load && frame_start) begin
      r_active  <= codes;
      r_shadow  <= codes;
      r_pending <= 1'b0;
    end else if (load) begin
      r_shadow  <= codes;
      r_pending <= 1'b1;
    end else if (frame_start && r_pending) begin
      r_active  <= r_shadow;
      r_pending <= 1'b0;
    end
  end

  assign pending = r_pending;

  // Widen to 11 bits so a box running past column 1023 never wraps back to x=0.
  logic [10:0] w_dx, w_dy, w_cx, w_cell_q, w_row_q, w_col_q;
  logic        w_inside, w_gap;

  assign w_dx     = {1'b0, x} - {1'b0, start_x};
  assign w_dy     = {1'b0, y} - {1'b0, start_y};
  assign w_inside = (x >= start_x) && (y >= start_y) &&
                    (w_dx < 11'(BOX_W)) && (w_dy < 11'(BOX_H));
  assign w_cell_q = w_dx / 11'(PITCH);
  assign w_cx     = w_dx % 11'(PITCH);
  assign w_row_q  = w_dy / 11'(SCALE);
  assign w_col_q  = w_cx / 11'(SCALE);
  assign w_gap    = (w_cx >= 11'(FONT_W*SCALE));

  logic              r_inside, r_gap;
  logic [CELL_W-1:0] r_cell;
  logic [2:0]        r_row, r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inside <= 1'b0;
      r_gap    <= 1'b0;
      r_cell   <= '0;
      r_row    <= '0;
      r_col    <= '0;
    end else begin
      r_inside <= w_inside;
      r_gap    <= w_gap;
      r_cell   <= w_cell_q[CELL_W-1:0];
      r_row    <= w_row_q[2:0];
      r_col    <= w_col_q[2:0];
    end
  end

  logic [CODE_W-1:0] w_code;
  logic [FONT_W-1:0] w_bits;
  logic              w_pix;
  logic              w_blink_ok;

  assign w_code = r_active[int'(r_cell)*CODE_W +: CODE_W];

  glyph_rom u_glyph_rom (
    .i_code (char_code_t'(w_code)),
    .i_row  (r_row),
    .o_bits (w_bits)
  );

  assign w_pix = (r_col <= 3'd4) ? w_bits[3'd4 - r_col] : 1'b0;

`ifdef CHAR_BLINK_EN
  localparam int BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BCNT_W-1:0] r_bcnt;
  logic              r_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt  <= '0;
      r_phase <= 1'b1;
    end else if (frame_start) begin
      if (r_bcnt == BCNT_W'(BLINK_FRAMES-1)) begin
        r_bcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_bcnt <= r_bcnt + 1'b1;
      end
    end
  end

  assign w_blink_ok = ~blink_mask[r_cell] | r_phase;

  logic w_unused;
  assign w_unused = &{1'b0, w_cell_q, w_row_q[10:3], w_col_q[10:3]};
`else
  assign w_blink_ok = 1'b1;

  logic w_unused;
  assign w_unused = &{1'b0, w_cell_q, w_row_q[10:3], w_col_q[10:3], blink_mask};
`endif

  logic r_display;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_display <= 1'b0;
    else        r_display <= r_inside & ~r_gap & w_pix & w_blink_ok;
  end

  assign display = r_display;

endmodule

// File: tb/tb_char_string_renderer.sv
// tb/tb_char_string_renderer.sv - directed checks of geometry, font pixels, commit and reset
module tb_char_string_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  x, y, start_x, start_y;
  logic        frame_start, load;
  logic [23:0] codes;
  logic [3:0]  blink_mask;
  logic        pending, display;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  char_string_renderer #(.BLINK_FRAMES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .x           (x),
    .y           (y),
    .start_x     (start_x),
    .start_y     (start_y),
    .frame_start (frame_start),
    .load        (load),
    .codes       (codes),
    .blink_mask  (blink_mask),
    .pending     (pending),
    .display     (display)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pack4(input int c3, input int c2, input int c1, input int c0);
    return {6'(c3), 6'(c2), 6'(c1), 6'(c0)};
  endfunction

  task automatic probe(input string tag, input int px, input int py, input logic exp);
    @(negedge clk);
    x = 10'(px);
    y = 10'(py);
    @(posedge clk);
    @(posedge clk);
    #1;
    check(tag, 32'(display), 32'(exp));
  endtask

  task automatic load_codes(input logic [23:0] c, input logic fs);
    @(negedge clk);
    codes       = c;
    load        = 1'b1;
    frame_start = fs;
    @(negedge clk);
    load        = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pulse_fs();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; x = 10'd100; y = 10'd50; start_x = 10'd100; start_y = 10'd50;
    frame_start = 1'b0; load = 1'b0; codes = '0; blink_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_display", 32'(display), 0);
    check("rst_pending", 32'(pending), 0);
    @(negedge clk);
    rst_n = 1'b1;
    probe("blank_after_rst", 100, 50, 1'b0);

    // "T" in cell 0 at (100,50)
    load_codes(pack4(0, 0, 0, 30), 1'b0);
    check("load_pending", 32'(pending), 1);
    pulse_fs();
    check("commit_pending", 32'(pending), 0);
    probe("T_topleft",   100, 50, 1'b1);
    probe("T_col0_end",  104, 50, 1'b1);
    probe("T_gap",       125, 50, 1'b0);
    probe("T_row1_col1", 105, 55, 1'b0);
    probe("T_row1_stem", 110, 55, 1'b1);
    probe("T_stem_row7", 112, 89, 1'b1);
    probe("below_box",   112, 90, 1'b0);
    probe("left_of_box",  99, 60, 1'b0);

    // "1234" loaded mid-frame: nothing changes until frame_start
    load_codes(pack4(5, 4, 3, 2), 1'b0);
    check("mid_pending", 32'(pending), 1);
    probe("old_T_kept",  100, 50, 1'b1);
    probe("old_cell1",   135, 50, 1'b0);
    pulse_fs();
    check("mid_commit_pending", 32'(pending), 0);
    probe("d2_row0_c0",  130, 50, 1'b0);
    probe("d2_row0_c1",  135, 50, 1'b1);
    probe("d2_row7_c0",  130, 87, 1'b1);
    probe("d2_row7_c4",  154, 87, 1'b1);
    probe("d1_row0_c0",  100, 50, 1'b0);
    probe("d1_row0_c2",  110, 50, 1'b1);

    // Repeated load overwrites shadow: A then T, commit shows T
    load_codes(pack4(0, 0, 0, 11), 1'b0);
    load_codes(pack4(0, 0, 0, 30), 1'b0);
    pulse_fs();
    probe("overwrite_T", 112, 89, 1'b1);

    // Load and frame_start together: bypass to active, pending stays 0
    load_codes(pack4(0, 0, 0, 11), 1'b1);
    check("bypass_pending", 32'(pending), 0);
    probe("A_row0_c0",   100, 50, 1'b0);
    probe("A_row0_c1",   105, 50, 1'b1);
    probe("A_row4_c0",   100, 70, 1'b1);
    pulse_fs();
    probe("idle_fs_keep", 105, 50, 1'b1);

    // Right-edge box: no wrap to low columns
    start_x = 10'd1000;
    load_codes(pack4(0, 0, 0, 30), 1'b1);
    probe("edge_c4_row0", 1020, 50, 1'b1);
    probe("edge_stem",    1012, 89, 1'b1);
    probe("edge_nowrap",     5, 50, 1'b0);
    probe("edge_c4_row7", 1023, 89, 1'b0);
    load_codes(pack4(0, 0, 0, 50), 1'b1);
    probe("code50_blank", 1000, 50, 1'b0);
    probe("code50_stem",  1012, 89, 1'b0);

    // Reset mid-frame with T shown and a pending shadow
    load_codes(pack4(0, 0, 0, 30), 1'b1);
    load_codes(pack4(0, 0, 0, 11), 1'b0);
    @(negedge clk);
    x = 10'd1000;
    y = 10'd50;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_on", 32'(display), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_display", 32'(display), 0);
    check("midrst_pending", 32'(pending), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_c1", 32'(display), 0);
    @(posedge clk);
    #1;
    check("post_rst_c2", 32'(display), 0);
    pulse_fs();
    probe("post_rst_blank", 1000, 50, 1'b0);

`ifdef CHAR_BLINK_EN
    start_x = 10'd100;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    blink_mask = 4'b0001;
    load_codes(pack4(30, 30, 30, 30), 1'b0);
    for (int f = 1; f <= 5; f++) begin
      pulse_fs();
      probe($sformatf("blink_c0_f%0d", f), 100, 50, (f == 2 || f == 3) ? 1'b0 : 1'b1);
      probe($sformatf("blink_c1_f%0d", f), 130, 50, 1'b1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
